adder3_arbiter: RTL and testbench
=================================

# adder3_arbiter

Round-robin arbiter and sequencer that shares one registered three-operand adder among `N_REQ` requesting FFT stages. Each requester offers an (A, B, C) operand triple over a valid/ready handshake. The block grants one requester per cycle, registers the wrap-around sum, and tags it with the winner's ID. It presents the result over a valid/ready output port with back-pressure.

## Interface
- `WORD_SIZE`, 16 — operand and sum width.
- `N_REQ`, 4 — number of requesters, ≥2.
- `ID_W`, `$clog2(N_REQ)` — requester ID width (derived, not overridden).

- `i_clk` — input, 1 — single clock, rising edge.
- `i_rst` — input, 1 — reset, synchronous, active-high.
- `i_req_valid` — input, `N_REQ` — per-requester operand valid.
- `o_req_ready` — output, `N_REQ` — one-hot grant; transfer when `valid & ready`.
- `i_req_a` — input, `N_REQ*WORD_SIZE` — operand A, requester k at `[k*WORD_SIZE +: WORD_SIZE]`.
- `i_req_b` — input, `N_REQ*WORD_SIZE` — operand B, same packing.
- `i_req_c` — input, `N_REQ*WORD_SIZE` — operand C, same packing.
- `o_res_valid` — output, 1 — result valid.
- `i_res_ready` — input, 1 — consumer accepts result.
- `o_res_sum` — output, `WORD_SIZE` — `(A+B+C) mod 2^WORD_SIZE`.
- `o_res_id` — output, `ID_W` — index of the requester that produced `o_res_sum`.

## Operation
- Reset (`i_rst` high at a clock edge):
  - `o_res_valid` = 0, `o_res_sum` = 0, `o_res_id` = 0.
  - Priority pointer = 0, so requester 0 has top priority.
  - `o_req_ready` is forced to all-zero while `i_rst` is high.
- Accept condition: `can_accept = !o_res_valid || i_res_ready`.
- Grant:
  - When `can_accept` holds, the highest-priority asserted `i_req_valid` gets its `o_req_ready` bit; otherwise `o_req_ready` = 0.
  - The grant is combinational from `i_req_valid`. It is at most one-hot and never asserted for a non-valid requester.
- Priority order: `ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1`, wrapping modulo `N_REQ`.
  - After a transfer from requester k, `ptr` becomes `(k+1) mod N_REQ`.
  - With no transfer, `ptr` is unchanged.
- Datapath on transfer:
  - `o_res_sum` ← `A+B+C`, truncated to `WORD_SIZE`; carries discarded, unsigned/two's-complement agnostic.
  - `o_res_id` ← k, `o_res_valid` ← 1.
- Output hold: while `o_res_valid && !i_res_ready`, `o_res_sum` and `o_res_id` are stable and no grant is issued.
- Drain: `o_res_valid && i_res_ready` with no new transfer → `o_res_valid` ← 0; sum and ID keep their last values.
- Simultaneous drain and accept: the new result replaces the old in the same edge. `o_res_valid` stays 1, giving full throughput of one result per cycle.
- Requester obligations: operands and valid stay stable until the transfer cycle. A requester may drop valid without a transfer; the arbiter tolerates this, and only sampled transfers count.
- Reset mid-operation: a pending result is discarded and not presented after reset. Requesters see no ready during reset and must re-offer.
- State: the output register plays the role of the state machine, with two states.
  - EMPTY (`o_res_valid`=0) → FULL on transfer.
  - FULL → FULL on accept-while-draining; FULL → EMPTY on drain without accept; FULL stays FULL while stalled.

## Timing
- Latency: transfer at edge t → result visible with `o_res_valid`=1 from t to t+1.
- Throughput: one result per cycle when `i_res_ready` is held high.
- Combinational paths:
  - `i_res_ready` → `o_req_ready`.
  - `i_req_valid` → `o_req_ready`.
  - No combinational path from `i_req_*` data to the outputs.
- Fairness: any continuously valid requester is granted within `N_REQ` transfers.

## Structure
- Shared package `fft_ctrl_pkg`:
  - `WORD_SIZE` default.
  - `ID_W` helper function.
  - Packed-operand slice macro/function reused by other FFT controllers.
- One natural sub-module: `rr_arbiter`, a parameterised `N_REQ` round-robin picker.
  - Inputs: request vector, enable, pointer.
  - Outputs: one-hot grant and encoded index.
  - Pointer update stays in the parent.
- The parent holds the pointer register, the operand mux, the three-input sum register and the output handshake.

## Test plan
- **Reset values:** assert `i_rst` with all valids high and `o_res_valid` previously 1 → `o_req_ready`=0, then `o_res_valid`=0, sum=0, id=0, pointer=0.
- **Single requester:** only requester 2 valid with A=0x0001, B=0x0002, C=0x0003, `i_res_ready`=1 → grant 2, next cycle sum=0x0006, id=2.
- **Wrap-around arithmetic:** A=0xFFFF, B=0xFFFF, C=0x0003 → sum=0x0001.
- **Round-robin:** all 4 valid, `i_res_ready`=1 → ids 0,1,2,3,0 on consecutive cycles with one result per cycle.
- **Back-pressure:** result held while `i_res_ready`=0 for 5 cycles → sum and id stable, no grants. Raise ready with a request pending → drain and new accept occur in the same edge.
- **Reset mid-stall:** `o_res_valid`=1, `i_res_ready`=0, then `i_rst` pulsed → result dropped, and requester 0 has priority afterwards.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT control blocks: default word size, ID width
// helper, result-register state encoding and a packed-operand slice macro.

`ifndef FFT_OPERAND_SLICE
// Select requester idx's w-bit field from a flat packed operand bus.
`define FFT_OPERAND_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package fft_ctrl_pkg;

    localparam int WORD_SIZE_DEF = 16;

    // Output register occupancy; the result register is the only state.
    typedef enum logic [0:0] {
        RES_EMPTY = 1'b0,
        RES_FULL  = 1'b1
    } res_state_e;

    // Width needed to encode an index among n requesters (at least one bit).
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: scans requests starting at ptr, wrapping modulo N_REQ,
// and returns the first asserted one as a one-hot grant plus encoded index.
// The pointer itself is owned and advanced by the parent.

module rr_arbiter
    import fft_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx
);

    logic [ID_W:0]   cand_s;
    logic            found_s;
    logic [N_REQ-1:0] grant_s;
    logic [ID_W-1:0]  idx_s;

    // Walk the priority order ptr, ptr+1, ... and latch onto the first request.
    always_comb begin
        grant_s = '0;
        idx_s   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_s = {1'b0, ptr} + (ID_W+1)'(i);
            if (cand_s >= (ID_W+1)'(N_REQ)) begin
                cand_s = cand_s - (ID_W+1)'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (en && !found_s && req[cand_s[ID_W-1:0]]) begin
                found_s                    = 1'b1;
                grant_s[cand_s[ID_W-1:0]]  = 1'b1;
                idx_s                      = cand_s[ID_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    assign grant = grant_s;
    assign idx   = idx_s;

endmodule

// File: rtl/adder3_arbiter.sv
// Shares one registered three-operand adder among N_REQ requesters. A
// round-robin grant is issued whenever the result register can take a new
// value; the wrap-around sum is registered together with the winner's ID and
// offered downstream over a valid/ready port with back-pressure.

module adder3_arbiter
    import fft_ctrl_pkg::*;
#(
    parameter int   WORD_SIZE = WORD_SIZE_DEF,
    parameter int   N_REQ     = 4,
    localparam int  ID_W      = id_width(N_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req_valid,
    output logic [N_REQ-1:0]          o_req_ready,
    input  logic [N_REQ*WORD_SIZE-1:0] i_req_a,
    input  logic [N_REQ*WORD_SIZE-1:0] i_req_b,
    input  logic [N_REQ*WORD_SIZE-1:0] i_req_c,
    output logic                      o_res_valid,
    input  logic                      i_res_ready,
    output logic [WORD_SIZE-1:0]      o_res_sum,
    output logic [ID_W-1:0]           o_res_id
);

    res_state_e            state_r;
    logic [ID_W-1:0]       ptr_r;
    logic [WORD_SIZE-1:0]  sum_r;
    logic [ID_W-1:0]       id_r;

    logic                  can_accept_s;
    logic                  grant_en_s;
    logic [N_REQ-1:0]      grant_s;
    logic [ID_W-1:0]       grant_idx_s;
    logic                  xfer_s;
    logic [ID_W-1:0]       next_ptr_s;
    logic [WORD_SIZE-1:0]  opnd_a_s;
    logic [WORD_SIZE-1:0]  opnd_b_s;
    logic [WORD_SIZE-1:0]  opnd_c_s;
    logic [WORD_SIZE-1:0]  sum_s;

    // A new operand set may enter when the register is empty or being drained;
    // no grant is ever shown while reset is asserted.
    assign can_accept_s = (state_r == RES_EMPTY) || i_res_ready;
    assign grant_en_s   = can_accept_s && !i_rst;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req   (i_req_valid),
        .en    (grant_en_s),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (grant_idx_s)
    );

    // The picker only grants valid requesters, so any grant is a transfer.
    assign xfer_s      = |grant_s;
    assign o_req_ready = grant_s;

    assign opnd_a_s = `FFT_OPERAND_SLICE(i_req_a, grant_idx_s, WORD_SIZE);
    assign opnd_b_s = `FFT_OPERAND_SLICE(i_req_b, grant_idx_s, WORD_SIZE);
    assign opnd_c_s = `FFT_OPERAND_SLICE(i_req_c, grant_idx_s, WORD_SIZE);
    assign sum_s    = opnd_a_s + opnd_b_s + opnd_c_s;

    // Priority moves to the requester just after the winner, wrapping at N_REQ.
    always_comb begin
        if (grant_idx_s == ID_W'(N_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_idx_s + ID_W'(1);
        end
    end

    // Result register, its occupancy state and the round-robin pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= RES_EMPTY;
            sum_r   <= '0;
            id_r    <= '0;
            ptr_r   <= '0;
        end else begin
            if (xfer_s) begin
                sum_r <= sum_s;
                id_r  <= grant_idx_s;
                ptr_r <= next_ptr_s;
            end
            case (state_r)
                RES_EMPTY: state_r <= xfer_s ? RES_FULL : RES_EMPTY;
                RES_FULL:  state_r <= (xfer_s || !i_res_ready) ? RES_FULL : RES_EMPTY;
                default:   state_r <= RES_EMPTY;
            endcase
        end
    end

    assign o_res_valid = (state_r == RES_FULL);
    assign o_res_sum   = sum_r;
    assign o_res_id    = id_r;

endmodule

// File: tb/tb_adder3_arbiter.sv
// Bench for adder3_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the arbiter/adder.

module tb_adder3_arbiter;

    localparam int WORD_SIZE = 16;
    localparam int N_REQ     = 4;
    localparam int ID_W      = 2;

    logic                       i_clk = 1'b0;
    logic                       i_rst;
    logic [N_REQ-1:0]           i_req_valid;
    logic [N_REQ-1:0]           o_req_ready;
    logic [N_REQ*WORD_SIZE-1:0] i_req_a;
    logic [N_REQ*WORD_SIZE-1:0] i_req_b;
    logic [N_REQ*WORD_SIZE-1:0] i_req_c;
    logic                       o_res_valid;
    logic                       i_res_ready;
    logic [WORD_SIZE-1:0]       o_res_sum;
    logic [ID_W-1:0]            o_res_id;

    always #5 i_clk = ~i_clk;

    adder3_arbiter #(
        .WORD_SIZE (WORD_SIZE),
        .N_REQ     (N_REQ)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_a     (i_req_a),
        .i_req_b     (i_req_b),
        .i_req_c     (i_req_c),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_res_sum   (o_res_sum),
        .o_res_id    (o_res_id)
    );

    // Requester-side offers and consumer/reset controls
    logic [15:0]      pa [N_REQ];
    logic [15:0]      pb [N_REQ];
    logic [15:0]      pc [N_REQ];
    logic [N_REQ-1:0] pv;
    bit               rst_v;
    bit               rdy_v;

    // Reference model state
    int  m_ptr;
    bit  m_valid;
    int  m_sum;
    int  m_id;
    int  last_win;

    int  err_cnt = 0;
    int  chk_cnt = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        i_rst       = rst_v;
        i_res_ready = rdy_v;
        i_req_valid = pv;
        for (int k = 0; k < N_REQ; k++) begin
            i_req_a[k*WORD_SIZE +: WORD_SIZE] = pa[k];
            i_req_b[k*WORD_SIZE +: WORD_SIZE] = pb[k];
            i_req_c[k*WORD_SIZE +: WORD_SIZE] = pc[k];
        end
    endtask

    // One clock: check outputs and grant mid-cycle, then advance the model.
    task automatic run_cycle();
        int  win;
        bit  can_acc;
        logic [N_REQ-1:0] exp_grant;
        drive_inputs();
        @(negedge i_clk);
        check_value("res_valid", 32'(o_res_valid), 32'(m_valid));
        check_value("res_sum", 32'(o_res_sum), m_sum);
        check_value("res_id", 32'(o_res_id), m_id);
        can_acc = !m_valid || rdy_v;
        win = -1;
        if (!rst_v && can_acc) begin
            for (int j = 0; j < N_REQ; j++) begin
                int idx;
                idx = (m_ptr + j) % N_REQ;
                if (win < 0 && pv[idx]) win = idx;
            end
        end
        exp_grant = '0;
        if (win >= 0) exp_grant[win] = 1'b1;
        check_value("req_ready", 32'(o_req_ready), 32'(exp_grant));
        @(posedge i_clk);
        last_win = win;
        if (rst_v) begin
            m_valid = 1'b0;
            m_sum   = 0;
            m_id    = 0;
            m_ptr   = 0;
        end else if (win >= 0) begin
            m_sum   = (int'(pa[win]) + int'(pb[win]) + int'(pc[win])) % 65536;
            m_id    = win;
            m_valid = 1'b1;
            m_ptr   = (win + 1) % N_REQ;
            pv[win] = 1'b0;
        end else if (rdy_v) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic offer(input int k, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        pa[k] = a;
        pb[k] = b;
        pc[k] = c;
        pv[k] = 1'b1;
    endtask

    task automatic offer_all_random();
        for (int k = 0; k < N_REQ; k++) begin
            if (!pv[k]) offer(k, 16'($urandom), 16'($urandom), 16'($urandom));
        end
    endtask

    initial begin
        int held_sum;
        int held_id;
        pv    = '0;
        rst_v = 1'b1;
        rdy_v = 1'b1;
        for (int k = 0; k < N_REQ; k++) begin
            pa[k] = 16'h0000;
            pb[k] = 16'h0000;
            pc[k] = 16'h0000;
        end
        // Initial reset: DUT state is unknown before it, so no checks yet
        drive_inputs();
        repeat (2) @(posedge i_clk);
        #1;
        m_ptr = 0; m_valid = 1'b0; m_sum = 0; m_id = 0;
        rst_v = 1'b0;
        run_cycle();

        // Single requester 2: 1+2+3
        offer(2, 16'h0001, 16'h0002, 16'h0003);
        run_cycle();
        check_value("single_valid", 32'(o_res_valid), 32'd1);
        check_value("single_sum", 32'(o_res_sum), 32'h0006);
        check_value("single_id", 32'(o_res_id), 32'd2);

        // Wrap-around arithmetic on requester 1
        offer(1, 16'hFFFF, 16'hFFFF, 16'h0003);
        run_cycle();
        check_value("wrap_sum", 32'(o_res_sum), 32'h0001);
        check_value("wrap_id", 32'(o_res_id), 32'd1);

        // Reset while a result is valid and every requester is asking
        offer_all_random();
        rst_v = 1'b1;
        run_cycle();
        check_value("rst_valid", 32'(o_res_valid), 32'd0);
        check_value("rst_sum", 32'(o_res_sum), 32'd0);
        check_value("rst_id", 32'(o_res_id), 32'd0);
        rst_v = 1'b0;

        // Round-robin with all requesters valid: ids 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            offer_all_random();
            run_cycle();
            check_value("rr_valid", 32'(o_res_valid), 32'd1);
            check_value("rr_id", 32'(o_res_id), 32'(i % N_REQ));
        end

        // Back-pressure: five stalled cycles, result held, no grants
        held_sum = m_sum;
        held_id  = m_id;
        rdy_v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer_all_random();
            run_cycle();
            check_value("hold_sum", 32'(o_res_sum), held_sum);
            check_value("hold_id", 32'(o_res_id), held_id);
        end
        // Release: drain and accept on the same edge (pointer sits at 1)
        rdy_v = 1'b1;
        run_cycle();
        check_value("refill_valid", 32'(o_res_valid), 32'd1);
        check_value("refill_id", 32'(o_res_id), 32'd1);

        // Reset during a stall drops the result; requester 0 wins afterwards
        rdy_v = 1'b0;
        offer_all_random();
        run_cycle();
        rst_v = 1'b1;
        run_cycle();
        rst_v = 1'b0;
        rdy_v = 1'b1;
        offer_all_random();
        run_cycle();
        check_value("post_rst_id", 32'(o_res_id), 32'd0);

        // Randomized traffic with sporadic back-pressure, drops and resets
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!pv[k] && ($urandom_range(0, 2) == 0)) begin
                    offer(k, 16'($urandom), 16'($urandom), 16'($urandom));
                end else if (pv[k] && ($urandom_range(0, 15) == 0)) begin
                    pv[k] = 1'b0;
                end
            end
            rdy_v = ($urandom_range(0, 9) < 7);
            rst_v = ($urandom_range(0, 99) == 0);
            run_cycle();
        end
        rst_v = 1'b0;
        rdy_v = 1'b1;
        pv    = '0;
        run_cycle();
        run_cycle();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
